// File: rtl/capture_scheduler.sv
// Acquisition sequencer: arms the enabled ADC drive blocks, waits for capture end,
// then drains each channel FIFO in ascending order onto one valid/ready byte stream.
// Optional build macro CH_HEADER_EN prefixes each channel frame with byte {4'hA, 1'b0, ch}.
module capture_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int FRAME_LEN   = 4096,
    parameter int CAP_TIMEOUT = 1000000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [NUM_CH-1:0]     Ch_mask,
    input  logic [NUM_CH-1:0]     Ch_end,
    input  logic [NUM_CH-1:0]     Ch_empty,
    input  logic [8*NUM_CH-1:0]   Ch_data,
    output logic [NUM_CH-1:0]     Ch_bg,
    output logic [NUM_CH-1:0]     Ch_rdreq,
    output logic [7:0]            Tx_data,
    output logic                  Tx_valid,
    input  logic                  Tx_ready,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Timeout_err
);

    localparam int              TO_W      = (CAP_TIMEOUT > 2) ? $clog2(CAP_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(CAP_TIMEOUT - 1);
    localparam logic [12:0]     FRAME_MAX = 13'(FRAME_LEN);

    // Tx handshake: a byte moves on a rising Clk edge where Tx_valid && Tx_ready;
    // Tx_data and Tx_valid are held unchanged while Tx_valid && !Tx_ready.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ARM      = 4'd1,
        S_WAIT_END = 4'd2,
        S_SEL      = 4'd3,
        S_RD_REQ   = 4'd4,
        S_RD_LAT   = 4'd5,
        S_SEND     = 4'd6,
        S_NEXT     = 4'd7
`ifdef CH_HEADER_EN
        ,S_HDR     = 4'd8
`endif
    } state_t;

    state_t            state_q;
    logic [NUM_CH-1:0] m_q;
    logic [2:0]        ch_q;
    logic [12:0]       bytecnt_q;
    logic [TO_W-1:0]   tocnt_q;
    logic [NUM_CH-1:0] bg_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              done_q;
    logic              terr_q;

    logic [7:0]        empty_ext;
    logic [63:0]       data_ext;
    logic [7:0]        onehot_ch;
    logic [7:0]        m_clr_ext;
    logic [NUM_CH-1:0] m_d;
    logic              rd_fire;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

    assign empty_ext = 8'(Ch_empty);
    assign data_ext  = 64'(Ch_data);
    assign onehot_ch = 8'd1 << ch_q;
    assign m_clr_ext = 8'(m_q) & ~onehot_ch;
    assign m_d       = m_clr_ext[NUM_CH-1:0];

    // The read strobe is issued during RD_REQ itself so the FIFO q is valid in RD_LAT.
    assign rd_fire  = (state_q == S_RD_REQ) && !empty_ext[ch_q] && (bytecnt_q != FRAME_MAX);
    assign Ch_rdreq = rd_fire ? onehot_ch[NUM_CH-1:0] : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            ch_q       <= '0;
            bytecnt_q  <= '0;
            tocnt_q    <= '0;
            bg_q       <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        m_q     <= Ch_mask;
                        terr_q  <= 1'b0;
                        tocnt_q <= '0;
                        if (Ch_mask == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            bg_q    <= Ch_mask;
                            state_q <= S_ARM;
                        end
                    end
                end
                S_ARM, S_WAIT_END: begin
                    if (tocnt_q == TO_LAST) begin
                        terr_q  <= 1'b1;
                        bg_q    <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        tocnt_q <= tocnt_q + 1'b1;
                        if (state_q == S_ARM) begin
                            // Drives acknowledge the restart by dropping their end flags.
                            if ((Ch_end & m_q) == '0) begin
                                bg_q    <= '0;
                                state_q <= S_WAIT_END;
                            end
                        end else if ((Ch_end & m_q) == m_q) begin
                            ch_q    <= lowest_set(8'(m_q));
                            state_q <= S_SEL;
                        end
                    end
                end
                S_SEL: begin
                    bytecnt_q <= '0;
`ifdef CH_HEADER_EN
                    tx_data_q  <= {4'hA, 1'b0, ch_q};
                    tx_valid_q <= 1'b1;
                    state_q    <= S_HDR;
`else
                    state_q    <= S_RD_REQ;
`endif
                end
`ifdef CH_HEADER_EN
                S_HDR: begin
                    if (Tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_RD_REQ;
                    end
                end
`endif
                S_RD_REQ: begin
                    state_q <= rd_fire ? S_RD_LAT : S_NEXT;
                end
                S_RD_LAT: begin
                    tx_data_q  <= data_ext[{ch_q, 3'b000} +: 8];
                    tx_valid_q <= 1'b1;
                    if (bytecnt_q != FRAME_MAX) bytecnt_q <= bytecnt_q + 13'd1;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (Tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_RD_REQ;
                    end
                end
                S_NEXT: begin
                    m_q <= m_d;
                    if (m_d == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        ch_q    <= lowest_set(8'(m_d));
                        state_q <= S_SEL;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Ch_bg       = bg_q;
    assign Tx_data     = tx_data_q;
    assign Tx_valid    = tx_valid_q;
    assign Busy        = (state_q != S_IDLE);
    assign Done        = done_q;
    assign Timeout_err = terr_q;

endmodule

// File: tb/tb_capture_scheduler.sv
// Bench for capture_scheduler: drive/FIFO models per channel, a byte scoreboard on the
// Tx stream, a table of acquisitions, and hand sequences for timeout, frame cap and reset.
module tb_capture_scheduler;

    localparam int NCH = 4;
    localparam int FLEN = 4096;
    localparam int CTO = 100;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [NCH-1:0]   Ch_mask;
    logic [NCH-1:0]   Ch_end;
    logic [NCH-1:0]   Ch_empty;
    logic [8*NCH-1:0] Ch_data;
    logic [NCH-1:0]   Ch_bg;
    logic [NCH-1:0]   Ch_rdreq;
    logic [7:0]       Tx_data;
    logic             Tx_valid;
    logic             Tx_ready;
    logic             Busy;
    logic             Done;
    logic             Timeout_err;

    capture_scheduler #(.NUM_CH(NCH), .FRAME_LEN(FLEN), .CAP_TIMEOUT(CTO)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ch_mask(Ch_mask), .Ch_end(Ch_end),
        .Ch_empty(Ch_empty), .Ch_data(Ch_data), .Ch_bg(Ch_bg), .Ch_rdreq(Ch_rdreq),
        .Tx_data(Tx_data), .Tx_valid(Tx_valid), .Tx_ready(Tx_ready), .Busy(Busy),
        .Done(Done), .Timeout_err(Timeout_err)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- bookkeeping ----------------
    int compared = 0;
    int mismatched = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- channel models ----------------
    logic           mdl_clr;
    logic [NCH-1:0] stuck;
    int             rdy_mode;
    int             fifo_len[NCH];
    int             rptr[NCH];
    int             phase[NCH];
    int             tmr[NCH];
    logic [7:0]     q_r[NCH];
    logic [NCH-1:0] end_r;
    logic [7:0]     rdy_cnt;

    always @(posedge Clk) begin
        rdy_cnt <= rdy_cnt + 8'd1;
        Tx_ready <= (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? rdy_cnt[1] : 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (mdl_clr) begin
                phase[i] <= 0;
                tmr[i]   <= 0;
                end_r[i] <= 1'b1;
                rptr[i]  <= 0;
                q_r[i]   <= 8'h00;
            end else begin
                if (Ch_rdreq[i]) begin
                    q_r[i]  <= 8'(rptr[i]);
                    rptr[i] <= rptr[i] + 1;
                end
                if (stuck[i]) begin
                    end_r[i] <= 1'b0;
                end else begin
                    case (phase[i])
                        0: if (Ch_bg[i] && end_r[i]) begin phase[i] <= 1; tmr[i] <= 3; end
                        1: if (tmr[i] == 1) begin end_r[i] <= 1'b0; phase[i] <= 2; tmr[i] <= 50; end
                           else tmr[i] <= tmr[i] - 1;
                        default: if (tmr[i] == 1) begin end_r[i] <= 1'b1; phase[i] <= 0; end
                                 else tmr[i] <= tmr[i] - 1;
                    endcase
                end
            end
        end
    end

    always_comb begin
        Ch_end   = end_r;
        Ch_empty = '0;
        Ch_data  = '0;
        for (int i = 0; i < NCH; i++) begin
            Ch_empty[i]       = (rptr[i] >= fifo_len[i]);
            Ch_data[i*8 +: 8] = q_r[i];
        end
    end

    // ---------------- scoreboard / protocol monitors ----------------
    int         done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       rd_out = 1'b0;

    always @(negedge Clk) begin
        if (Done) done_cnt++;
        if (Reset) begin
            prev_stall = 1'b0;
            rd_out = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", {31'b0, Tx_valid}, 32'd1);
                check("tx_hold_data", {24'b0, Tx_data}, {24'b0, prev_data});
            end
            if (|Ch_rdreq) begin
                check("rdreq_onehot", {31'b0, $onehot(Ch_rdreq)}, 32'd1);
                check("rdreq_on_empty", {28'b0, Ch_rdreq & Ch_empty}, 32'd0);
                check("rdreq_no_handshake", {31'b0, rd_out}, 32'd0);
                rd_out = 1'b1;
            end
            if (Tx_valid && Tx_ready) begin
                rd_out = 1'b0;
                if (exp_q.size() == 0) begin
                    check("tx_unexpected_byte", {24'b0, Tx_data}, 32'h100);
                end else begin
                    check("tx_byte", {24'b0, Tx_data}, {24'b0, exp_q.pop_front()});
                end
            end
            prev_stall = Tx_valid && !Tx_ready;
            prev_data  = Tx_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_models(input int len, input int mode);
        rdy_mode = mode;
        for (int i = 0; i < NCH; i++) fifo_len[i] = len;
        @(negedge Clk);
        mdl_clr = 1'b1;
        @(negedge Clk);
        mdl_clr = 1'b0;
    endtask

    task automatic push_expected(input logic [NCH-1:0] mask, input int len);
        logic [2:0] chb;
        int n;
        n = (len < FLEN) ? len : FLEN;
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                chb = 3'(c);
`ifdef CH_HEADER_EN
                exp_q.push_back({4'hA, 1'b0, chb});
`endif
                for (int k = 0; k < n; k++) exp_q.push_back(8'(k));
            end
        end
    endtask

    task automatic run_acq(input string name, input logic [NCH-1:0] mask, input int mode,
                           input int len, input bit push, input int exp_done,
                           input bit exp_terr, output int busy_cycles);
        int base;
        bit finished;
        load_models(len, mode);
        if (push) push_expected(mask, len);
        base = done_cnt;
        Start   = 1'b1;
        Ch_mask = mask;
        @(negedge Clk);
        Start = 1'b0;
        busy_cycles = 0;
        finished = 1'b0;
        for (int k = 0; k < 30000; k++) begin
            if (!Busy) begin
                finished = 1'b1;
                break;
            end
            busy_cycles++;
            @(negedge Clk);
        end
        #1;
        check({name, "_finished"}, {31'b0, finished}, 32'd1);
        check({name, "_done_pulses"}, 32'(done_cnt - base), 32'(exp_done));
        check({name, "_timeout_err"}, {31'b0, Timeout_err}, {31'b0, exp_terr});
        check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_bg_idle"}, {28'b0, Ch_bg}, 32'd0);
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string          name;
        logic [NCH-1:0] mask;
        int             rdy_mode;
        int             len;
        int             exp_done;
    } vec_t;

    vec_t vecs[6];
    int   bc;

    initial begin
        Reset = 1'b1; Start = 1'b0; Ch_mask = '0; mdl_clr = 1'b1; stuck = '0;
        rdy_mode = 0; rdy_cnt = 8'd0;
        for (int i = 0; i < NCH; i++) fifo_len[i] = 0;

        vecs[0] = '{"mask0000",    4'b0000, 0, 16, 1};
        vecs[1] = '{"mask0101",    4'b0101, 0, 16, 1};
        vecs[2] = '{"mask0101_bp", 4'b0101, 1, 16, 1};
        vecs[3] = '{"mask1111_bp", 4'b1111, 1, 3,  1};
        vecs[4] = '{"mask1000",    4'b1000, 0, 4,  1};
        vecs[5] = '{"mask0110_mt", 4'b0110, 0, 0,  1};

        repeat (3) @(negedge Clk);
        Reset = 1'b0; mdl_clr = 1'b0;
        #1;
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_done", {31'b0, Done}, 32'd0);
        check("rst_terr", {31'b0, Timeout_err}, 32'd0);
        check("rst_txv", {31'b0, Tx_valid}, 32'd0);
        check("rst_txd", {24'b0, Tx_data}, 32'd0);
        check("rst_bg", {28'b0, Ch_bg}, 32'd0);
        check("rst_rdreq", {28'b0, Ch_rdreq}, 32'd0);

        // Empty mask: Done the cycle after Start, never busy.
        @(negedge Clk);
        Start = 1'b1; Ch_mask = '0;
        @(negedge Clk);
        Start = 1'b0;
        check("m0_done_next", {31'b0, Done}, 32'd1);
        check("m0_busy", {31'b0, Busy}, 32'd0);
        check("m0_bg", {28'b0, Ch_bg}, 32'd0);
        @(negedge Clk);
        check("m0_done_pulse", {31'b0, Done}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_acq(vecs[v].name, vecs[v].mask, vecs[v].rdy_mode, vecs[v].len, 1'b1,
                    vecs[v].exp_done, 1'b0, bc);
        end

        // Capture timeout with ch1 never finishing.
        stuck = 4'b0010;
        run_acq("timeout", 4'b0010, 0, 16, 1'b0, 0, 1'b1, bc);
        check("timeout_busy_cycles", 32'(bc), 32'(CTO));
        stuck = '0;
        run_acq("terr_clear", 4'b0000, 0, 16, 1'b0, 1, 1'b0, bc);

        // Frame length cap.
        run_acq("frame_cap", 4'b0001, 0, 5000, 1'b1, 1, 1'b0, bc);

        // Reset while a byte waits for the sink.
        load_models(16, 2);
        Start = 1'b1; Ch_mask = 4'b0001;
        @(negedge Clk);
        Start = 1'b0;
        bc = 0;
        while (!Tx_valid && bc < 300) begin
            @(negedge Clk);
            bc++;
        end
        check("rsend_reached", {31'b0, Tx_valid}, 32'd1);
        #2 Reset = 1'b1;
        @(negedge Clk);
        check("rsend_txv", {31'b0, Tx_valid}, 32'd0);
        check("rsend_txd", {24'b0, Tx_data}, 32'd0);
        check("rsend_busy", {31'b0, Busy}, 32'd0);
        check("rsend_bg", {28'b0, Ch_bg}, 32'd0);
        check("rsend_rdreq", {28'b0, Ch_rdreq}, 32'd0);
        check("rsend_done", {31'b0, Done}, 32'd0);

        // Start coincident with Reset is dropped.
        Start = 1'b1; Ch_mask = 4'b0001;
        @(negedge Clk);
        Start = 1'b0; Reset = 1'b0;
        check("rst_start_busy", {31'b0, Busy}, 32'd0);
        check("rst_start_bg", {28'b0, Ch_bg}, 32'd0);
        @(negedge Clk);
        check("rst_start_busy2", {31'b0, Busy}, 32'd0);

        // Normal operation resumes after reset.
        run_acq("post_reset", 4'b0011, 1, 5, 1'b1, 1, 1'b0, bc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/capture_scheduler.md
Name: capture_scheduler

Overview:
- Sequences the per-channel ADC capture blocks (ADCn_drive) for one acquisition.
- Arms every enabled channel, waits for all of them to finish capturing, then drains each channel's FIFO in ascending channel order.
- Drained bytes go onto one shared byte stream with a valid/ready handshake, toward the host link (UART/MCU interface).
- Sits between the host command decoder and the ADC drive instances.

Parameters:
- NUM_CH, 4, number of ADC channels scheduled (1..8).
- FRAME_LEN, 4096, maximum bytes drained per channel per acquisition.
- CAP_TIMEOUT, 1000000, Clk cycles allowed in ARM plus WAIT_END before abort.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle acquisition request
- Ch_mask  in  NUM_CH  channel enables, sampled on accepted Start
- Ch_end  in  NUM_CH  capture-complete flags from drive blocks
- Ch_empty  in  NUM_CH  FIFO empty flags from drive blocks
- Ch_data  in  8*NUM_CH  FIFO q buses; channel i on bits [8i+7:8i]
- Ch_bg  out  NUM_CH  capture (re)start request per channel
- Ch_rdreq  out  NUM_CH  FIFO read strobe, one-hot or zero
- Tx_data  out  8  output byte
- Tx_valid  out  1  Tx_data valid
- Tx_ready  in  1  sink accepts the byte when Tx_valid&&Tx_ready
- Busy  out  1  high whenever state != IDLE
- Done  out  1  one-cycle pulse when an acquisition completes
- Timeout_err  out  1  sticky abort flag; cleared by the next accepted Start

Behaviour:
- Reset values: all outputs 0, state IDLE, internal mask/counters 0. Reset asserted mid-operation forces this state on the next edge and aborts any transfer.
- IDLE:
  - Start accepted only here; Start is ignored while Busy.
  - On accept: latch Ch_mask to m, clear Timeout_err, clear the timeout counter.
  - If m==0: pulse Done on the next cycle and stay in IDLE.
  - Otherwise go to ARM.
- ARM:
  - Ch_bg = m.
  - Leave when (Ch_end & m)==0, i.e. the drives have restarted. Then Ch_bg <= 0 and go to WAIT_END.
- WAIT_END:
  - Leave when (Ch_end & m)==m. Set ch = lowest set bit of m and go to SEL.
- Timeout:
  - Counter increments every cycle in ARM and WAIT_END.
  - When it reaches CAP_TIMEOUT-1: Timeout_err <= 1, Ch_bg <= 0, go IDLE, no Done.
- SEL:
  - Clear the byte counter.
  - Go to HDR if CH_HEADER_EN is defined, else RD_REQ.
- RD_REQ:
  - If Ch_empty[ch] or bytecnt==FRAME_LEN: go to NEXT.
  - Else assert Ch_rdreq[ch] for exactly one cycle and go to RD_LAT.
- RD_LAT:
  - FIFO q is valid one cycle after rdreq.
  - Tx_data <= Ch_data[ch], Tx_valid <= 1, bytecnt++, go to SEND.
- SEND:
  - Hold Tx_data and Tx_valid stable until Tx_ready.
  - On handshake: Tx_valid <= 0, go to RD_REQ.
  - Throughput is at most 1 byte per 3 cycles; this is acceptable.
- NEXT:
  - Clear bit ch in m.
  - If m is now 0: Done pulse, go IDLE.
  - Else ch = next lowest set bit, go to SEL.
- Rdreq never asserts when Ch_empty[ch]==1. At most one channel is read at a time.
- bytecnt is 13 bits and saturates at FRAME_LEN; there is no wrap.
- Start coincident with Reset: Reset wins.

Optional Feature:
- Macro: CH_HEADER_EN.
- Defined:
  - Each channel frame is preceded by a HDR state.
  - HDR sends byte {4'hA, 1'b0, ch[2:0]} using the same valid/ready rule, then goes to RD_REQ.
  - The header does not count toward FRAME_LEN.
- Undefined: the HDR state and logic are absent, and frames are raw bytes only.

Test Plan:
1. Reset, then Start with Ch_mask=4'b0000 -> Done pulse on the next cycle, Busy stays 0, no Ch_bg.
2. Ch_mask=4'b0101. Models: Ch_end drops 3 cycles after Ch_bg and rises 50 cycles later; each FIFO holds 16 bytes 0x00..0x0F; Tx_ready=1 -> 32 bytes out, ch0 then ch2, each ascending 0x00..0x0F, then one Done pulse.
3. Same as 2 with Tx_ready toggling every 2 cycles -> identical byte sequence, Tx_data stable while Tx_valid&&!Tx_ready, Ch_rdreq never asserted twice without a handshake between.
4. Ch_mask=4'b0010 with Ch_end[1] held at 0 and CAP_TIMEOUT=100 -> Timeout_err=1 after 100 Busy cycles, Busy 0, no Done; next Start clears Timeout_err.
5. FIFO of 5000 bytes with FRAME_LEN=4096 -> exactly 4096 bytes sent, then NEXT/Done. Separately, Reset asserted during SEND -> all outputs 0 the following cycle.
6. CH_HEADER_EN defined, Ch_mask=4'b1000, 4-byte FIFO -> stream 0xA3 followed by 4 data bytes, then Done.
